fma16_vec_runner: RTL and testbench
===================================

# fma16_vec_runner

Synthesizable test-vector sequencer sitting directly upstream of `fma16`. It fetches 76-bit vectors from a synchronous vector memory, unpacks them onto the `fma16` operand and control inputs, samples the combinational `result`/`flags`, compares them against the expected fields, and keeps error statistics. It lets the fma16 exercise run on FPGA or in lint-clean simulation without a behavioural testbench loop.

## Interface
- `AW`, 14: vector memory address width; up to 2^AW vectors.
- `CHECK_FLAGS`, 0: 1 = a flag mismatch also counts as an error.
- `clk` in 1: clock.
- `reset` in 1: asynchronous, active-high reset.
- `start` in 1: begin a run; sampled only in IDLE or DONE.
- `num_vecs` in AW+1: vector count, sampled on accepted `start`.
- `vec_addr` out AW: vector memory read address.
- `vec_data` in 76: read data, valid one cycle after `vec_addr`.
- `x`, `y`, `z` out 16 each: fma16 operands.
- `mul`, `add`, `negp`, `negz` out 1 each: fma16 controls.
- `roundmode` out 2: fma16 rounding mode.
- `result` in 16: fma16 result.
- `flags` in 4: fma16 flags {invalid, overflow, underflow, inexact}.
- `busy` out 1: run in progress.
- `done` out 1: run complete; held until the next `start`.
- `vectornum` out 32: vectors checked so far.
- `errors` out 32: mismatching vectors so far.
- `err_pulse` out 1: one-cycle pulse on each mismatch.
- `first_err_idx` out AW: index of the first mismatch.
- `first_err_valid` out 1: `first_err_idx` is meaningful.

## Operation
- Vector layout: x[75:60], y[59:44], z[43:28], ctrl[27:20], rexp[19:4], fexp[3:0].
- ctrl[5:0] = {roundmode, mul, add, negp, negz}; ctrl[7:6] ignored.
- FSM states: IDLE, FETCH, APPLY, CHECK, DONE.
- IDLE/DONE + `start`:
  - clears `vectornum`, `errors`, `first_err_valid` and the index;
  - latches `num_vecs`;
  - goes to DONE if `num_vecs`==0, otherwise FETCH.
- FETCH: drive `vec_addr`=index; go to APPLY.
- APPLY:
  - register `vec_data` fields onto the fma16 outputs and into internal rexp/fexp registers;
  - go to CHECK.
- CHECK:
  - mismatch = (result != rexp) | (CHECK_FLAGS & (flags != fexp));
  - `vectornum`++;
  - on mismatch: `errors`++ and pulse `err_pulse`; if `!first_err_valid`, capture the index and set `first_err_valid`;
  - index++;
  - go to DONE if the new index == latched count, otherwise FETCH.
- DONE: `done`=1 and all counters hold; fma16 outputs keep the last vector.
- `busy` = FETCH | APPLY | CHECK.
- `start` in any busy state is ignored.
- Counters saturate at 2^32-1; they never wrap.
- Index width AW+1, so `num_vecs`=2^AW is legal.

## Timing
- Reset (asynchronous, any state):
  - FSM goes to IDLE;
  - every output is 0 (`x`/`y`/`z`/controls/`roundmode`/`vec_addr`, `busy`, `done`, counters, `err_pulse`, `first_err_*`).
- A run aborted by reset leaves no residue; the next `start` begins at index 0.
- 3 cycles per vector; a run of N vectors sets `done` 3N+1 cycles after the `start` edge.
- Operands are stable for the whole CHECK cycle; fma16 has one full cycle of combinational settling.
- Memory contract: synchronous read, data valid the cycle after the address is presented.
- `vec_addr` holds during APPLY.
- `err_pulse` is registered; it is high the cycle after the failing CHECK, aligned with the updated `errors`.
- `start` asserted in the same cycle DONE is entered is ignored; restart requires `start` while in DONE.

## Structure
- Package `fma16_tv_pkg`:
  - field bit-position localparams (X_MSB … FEXP_LSB);
  - ctrl bit positions;
  - `tv_state_t` enum;
  - `fma16_tv_t` packed struct {x, y, z, ctrl, rexp, fexp} overlaying the 76-bit word.
- Sub-module `fma16_tv_unpack`: combinational 76-bit word → struct fields plus decoded controls; shared with the behavioural bench.
- `fma16` is instantiated beside the runner, not inside it.

## Test plan
- Reset mid-run: assert `reset` during APPLY of vector 2 → all outputs 0 immediately; after `start`, fetch restarts at `vec_addr`=0.
- Pass path: memory[0]=3c00_3c00_0000_08_3c00_0 (1.0×1.0, mul=1) with the real fma16, `num_vecs`=1 → `mul`=1, `roundmode`=0, `errors`=0, `vectornum`=1, `done` on cycle 4.
- Result mismatch: memory[0..2] with rexp of [1] corrupted to 3c01 → single `err_pulse`, `errors`=1, `first_err_idx`=1, `vectornum`=3.
- Flag check: result correct, fexp=1 vs `flags`=0 → `errors`=0 with CHECK_FLAGS=0; `errors`=1 with CHECK_FLAGS=1.
- Boundaries:
  - `num_vecs`=0 → DONE next cycle, no memory reads;
  - `start` pulsed while `busy` → no effect;
  - `start` in DONE → counters clear and the run repeats.
- Full depth: AW=4, `num_vecs`=16, all passing → `vectornum`=16, `done` at cycle 49, `vec_addr` sequence 0..15.

Source files
------------

// File: rtl/fma16_tv_pkg.sv
// Shared definitions for the fma16 test-vector runner: the 76-bit vector
// layout, control-byte bit positions, runner states and a saturating counter helper.
package fma16_tv_pkg;

   localparam int TV_W      = 76;

   localparam int X_MSB     = 75;
   localparam int X_LSB     = 60;
   localparam int Y_MSB     = 59;
   localparam int Y_LSB     = 44;
   localparam int Z_MSB     = 43;
   localparam int Z_LSB     = 28;
   localparam int CTRL_MSB  = 27;
   localparam int CTRL_LSB  = 20;
   localparam int REXP_MSB  = 19;
   localparam int REXP_LSB  = 4;
   localparam int FEXP_MSB  = 3;
   localparam int FEXP_LSB  = 0;

   // bit positions inside the 8-bit ctrl field; bits 7:6 are spare
   localparam int CTRL_NEGZ   = 0;
   localparam int CTRL_NEGP   = 1;
   localparam int CTRL_ADD    = 2;
   localparam int CTRL_MUL    = 3;
   localparam int CTRL_RM_LSB = 4;
   localparam int CTRL_RM_MSB = 5;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_FETCH = 3'd1,
      ST_APPLY = 3'd2,
      ST_CHECK = 3'd3,
      ST_DONE  = 3'd4
   } tv_state_t;

   typedef struct packed {
      logic [15:0] x;
      logic [15:0] y;
      logic [15:0] z;
      logic [7:0]  ctrl;
      logic [15:0] rexp;
      logic [3:0]  fexp;
   } fma16_tv_t;

   // statistics counters stick at all-ones instead of wrapping
   function automatic logic [31:0] sat_inc32(input logic [31:0] v);
      return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
   endfunction

endpackage

// File: rtl/fma16_vec_runner_unpack.sv
// Combinational split of one vector word into operands, decoded controls
// and the expected result/flags.
module fma16_tv_unpack
   import fma16_tv_pkg::*;
(
   input  logic [TV_W-1:0] word_i,
   output logic [15:0]     x_o,
   output logic [15:0]     y_o,
   output logic [15:0]     z_o,
   output logic            mul_o,
   output logic            add_o,
   output logic            negp_o,
   output logic            negz_o,
   output logic [1:0]      roundmode_o,
   output logic [15:0]     rexp_o,
   output logic [3:0]      fexp_o
);

   fma16_tv_t tv;

   assign tv          = fma16_tv_t'(word_i);
   assign x_o         = tv.x;
   assign y_o         = tv.y;
   assign z_o         = tv.z;
   assign mul_o       = tv.ctrl[CTRL_MUL];
   assign add_o       = tv.ctrl[CTRL_ADD];
   assign negp_o      = tv.ctrl[CTRL_NEGP];
   assign negz_o      = tv.ctrl[CTRL_NEGZ];
   assign roundmode_o = tv.ctrl[CTRL_RM_MSB:CTRL_RM_LSB];
   assign rexp_o      = tv.rexp;
   assign fexp_o      = tv.fexp;

endmodule

// File: rtl/fma16_vec_runner.sv
// Test-vector sequencer for fma16: fetch, apply, check, count errors.
//
// state | meaning
// IDLE  | after reset, waiting for start
// FETCH | vec_addr presents the current index to the vector memory
// APPLY | memory data valid; latch operands, controls and expectations
// CHECK | fma16 has settled; compare, update counters, advance index
// DONE  | run complete, everything held until the next start
module fma16_vec_runner
   import fma16_tv_pkg::*;
#(
   parameter int AW          = 14,
   parameter bit CHECK_FLAGS = 1'b0
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            start,
   input  logic [AW:0]     num_vecs,
   output logic [AW-1:0]   vec_addr,
   input  logic [TV_W-1:0] vec_data,
   output logic [15:0]     x,
   output logic [15:0]     y,
   output logic [15:0]     z,
   output logic            mul,
   output logic            add,
   output logic            negp,
   output logic            negz,
   output logic [1:0]      roundmode,
   input  logic [15:0]     result,
   input  logic [3:0]      flags,
   output logic            busy,
   output logic            done,
   output logic [31:0]     vectornum,
   output logic [31:0]     errors,
   output logic            err_pulse,
   output logic [AW-1:0]   first_err_idx,
   output logic            first_err_valid
);

   localparam logic [AW:0] IDX_ONE = {{AW{1'b0}}, 1'b1};

   tv_state_t   state_q, state_d;
   logic [AW:0] idx_q, idx_d, cnt_q, cnt_d;
   logic [15:0] x_q, x_d, y_q, y_d, z_q, z_d, rexp_q, rexp_d;
   logic [3:0]  fexp_q, fexp_d;
   logic        mul_q, mul_d, add_q, add_d, negp_q, negp_d, negz_q, negz_d;
   logic [1:0]  rm_q, rm_d;
   logic [31:0] vnum_q, vnum_d, errs_q, errs_d;
   logic        err_pulse_q, err_pulse_d, ferr_vld_q, ferr_vld_d;
   logic [AW-1:0] ferr_idx_q, ferr_idx_d;

   logic [15:0] u_x, u_y, u_z, u_rexp;
   logic [3:0]  u_fexp;
   logic        u_mul, u_add, u_negp, u_negz;
   logic [1:0]  u_rm;
   logic        mismatch;
   logic [AW:0] idx_next;

   fma16_tv_unpack u_unpack (
      .word_i      (vec_data),
      .x_o         (u_x),
      .y_o         (u_y),
      .z_o         (u_z),
      .mul_o       (u_mul),
      .add_o       (u_add),
      .negp_o      (u_negp),
      .negz_o      (u_negz),
      .roundmode_o (u_rm),
      .rexp_o      (u_rexp),
      .fexp_o      (u_fexp)
   );

   assign mismatch = (result != rexp_q) | (CHECK_FLAGS & (flags != fexp_q));
   assign idx_next = idx_q + IDX_ONE;

   // next-state and datapath updates; registers hold unless a state says otherwise
   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      cnt_d       = cnt_q;
      x_d         = x_q;
      y_d         = y_q;
      z_d         = z_q;
      mul_d       = mul_q;
      add_d       = add_q;
      negp_d      = negp_q;
      negz_d      = negz_q;
      rm_d        = rm_q;
      rexp_d      = rexp_q;
      fexp_d      = fexp_q;
      vnum_d      = vnum_q;
      errs_d      = errs_q;
      err_pulse_d = 1'b0;
      ferr_idx_d  = ferr_idx_q;
      ferr_vld_d  = ferr_vld_q;
      unique case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               vnum_d     = '0;
               errs_d     = '0;
               ferr_vld_d = 1'b0;
               ferr_idx_d = '0;
               idx_d      = '0;
               cnt_d      = num_vecs;
               state_d    = (num_vecs == '0) ? ST_DONE : ST_FETCH;
            end
         end
         ST_FETCH: state_d = ST_APPLY;
         ST_APPLY: begin
            x_d     = u_x;
            y_d     = u_y;
            z_d     = u_z;
            mul_d   = u_mul;
            add_d   = u_add;
            negp_d  = u_negp;
            negz_d  = u_negz;
            rm_d    = u_rm;
            rexp_d  = u_rexp;
            fexp_d  = u_fexp;
            state_d = ST_CHECK;
         end
         ST_CHECK: begin
            vnum_d = sat_inc32(vnum_q);
            if (mismatch) begin
               errs_d      = sat_inc32(errs_q);
               err_pulse_d = 1'b1;
               if (!ferr_vld_q) begin
                  ferr_idx_d = idx_q[AW-1:0];
                  ferr_vld_d = 1'b1;
               end
            end
            idx_d   = idx_next;
            state_d = (idx_next == cnt_q) ? ST_DONE : ST_FETCH;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // state register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= ST_IDLE;
      else       state_q <= state_d;
   end

   // datapath and statistics registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         idx_q       <= '0;
         cnt_q       <= '0;
         x_q         <= '0;
         y_q         <= '0;
         z_q         <= '0;
         mul_q       <= 1'b0;
         add_q       <= 1'b0;
         negp_q      <= 1'b0;
         negz_q      <= 1'b0;
         rm_q        <= '0;
         rexp_q      <= '0;
         fexp_q      <= '0;
         vnum_q      <= '0;
         errs_q      <= '0;
         err_pulse_q <= 1'b0;
         ferr_idx_q  <= '0;
         ferr_vld_q  <= 1'b0;
      end else begin
         idx_q       <= idx_d;
         cnt_q       <= cnt_d;
         x_q         <= x_d;
         y_q         <= y_d;
         z_q         <= z_d;
         mul_q       <= mul_d;
         add_q       <= add_d;
         negp_q      <= negp_d;
         negz_q      <= negz_d;
         rm_q        <= rm_d;
         rexp_q      <= rexp_d;
         fexp_q      <= fexp_d;
         vnum_q      <= vnum_d;
         errs_q      <= errs_d;
         err_pulse_q <= err_pulse_d;
         ferr_idx_q  <= ferr_idx_d;
         ferr_vld_q  <= ferr_vld_d;
      end
   end

   // the address is simply the index, so it holds through APPLY and CHECK
   assign vec_addr        = idx_q[AW-1:0];
   assign x               = x_q;
   assign y               = y_q;
   assign z               = z_q;
   assign mul             = mul_q;
   assign add             = add_q;
   assign negp            = negp_q;
   assign negz            = negz_q;
   assign roundmode       = rm_q;
   assign busy            = (state_q == ST_FETCH) || (state_q == ST_APPLY) || (state_q == ST_CHECK);
   assign done            = (state_q == ST_DONE);
   assign vectornum       = vnum_q;
   assign errors          = errs_q;
   assign err_pulse       = err_pulse_q;
   assign first_err_idx   = ferr_idx_q;
   assign first_err_valid = ferr_vld_q;

endmodule

// File: tb/tb_fma16_vec_runner.sv
// Bench: two runners (flag checking off/on) share one vector memory image and
// a stand-in fma16 whose result/flags are a known function of its inputs.
module tb_fma16_vec_runner;
   import fma16_tv_pkg::*;

   localparam int AW    = 4;
   localparam int DEPTH = 16;

   logic clk = 1'b0;
   logic reset, start;
   logic [AW:0] num_vecs;
   logic [75:0] mem [DEPTH];

   logic [AW-1:0] addr0, addr1, fei0, fei1;
   logic [75:0]   data0, data1;
   logic [15:0]   x0, y0, z0, x1, y1, z1, res0, res1;
   logic          mul0, add0, negp0, negz0, mul1, add1, negp1, negz1;
   logic [1:0]    rm0, rm1;
   logic [3:0]    fl0, fl1;
   logic          busy0, done0, ep0, fev0, busy1, done1, ep1, fev1;
   logic [31:0]   vn0, er0, vn1, er1;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   // stand-in fma16: deterministic function of operands and ctrl {rm,mul,add,negp,negz}
   function automatic logic [15:0] fake_res(input logic [15:0] a, input logic [15:0] b,
                                            input logic [15:0] c, input logic [5:0] ctl);
      logic [15:0] r;
      r = ctl[3] ? (a & b) : (a | b);
      r = r ^ c ^ {14'b0, ctl[5:4]} ^ {ctl[1], ctl[0], 14'b0};
      if (ctl[2]) r = r + 16'h0101;
      return r;
   endfunction

   function automatic logic [3:0] fake_flags(input logic [15:0] a, input logic [15:0] b,
                                             input logic [15:0] c, input logic [5:0] ctl);
      return {a[0], b[0], c[0], ctl[2]};
   endfunction

   assign res0 = fake_res(x0, y0, z0, {rm0, mul0, add0, negp0, negz0});
   assign fl0  = fake_flags(x0, y0, z0, {rm0, mul0, add0, negp0, negz0});
   assign res1 = fake_res(x1, y1, z1, {rm1, mul1, add1, negp1, negz1});
   assign fl1  = fake_flags(x1, y1, z1, {rm1, mul1, add1, negp1, negz1});

   // synchronous-read vector memory, one port per runner
   always @(posedge clk) begin
      data0 <= mem[addr0];
      data1 <= mem[addr1];
   end

   fma16_vec_runner #(.AW(AW), .CHECK_FLAGS(1'b0)) dut0 (
      .clk(clk), .reset(reset), .start(start), .num_vecs(num_vecs),
      .vec_addr(addr0), .vec_data(data0), .x(x0), .y(y0), .z(z0),
      .mul(mul0), .add(add0), .negp(negp0), .negz(negz0), .roundmode(rm0),
      .result(res0), .flags(fl0), .busy(busy0), .done(done0),
      .vectornum(vn0), .errors(er0), .err_pulse(ep0),
      .first_err_idx(fei0), .first_err_valid(fev0)
   );

   fma16_vec_runner #(.AW(AW), .CHECK_FLAGS(1'b1)) dut1 (
      .clk(clk), .reset(reset), .start(start), .num_vecs(num_vecs),
      .vec_addr(addr1), .vec_data(data1), .x(x1), .y(y1), .z(z1),
      .mul(mul1), .add(add1), .negp(negp1), .negz(negz1), .roundmode(rm1),
      .result(res1), .flags(fl1), .busy(busy1), .done(done1),
      .vectornum(vn1), .errors(er1), .err_pulse(ep1),
      .first_err_idx(fei1), .first_err_valid(fev1)
   );

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_all_zero(input string tag);
      check_eq({tag, "_addr0"},  32'(addr0), 32'd0);
      check_eq({tag, "_xyz0"},   32'(x0 | y0 | z0), 32'd0);
      check_eq({tag, "_ctl0"},   32'({rm0, mul0, add0, negp0, negz0}), 32'd0);
      check_eq({tag, "_stat0"},  32'({busy0, done0, ep0, fev0}), 32'd0);
      check_eq({tag, "_vn0"},    vn0, 32'd0);
      check_eq({tag, "_er0"},    er0, 32'd0);
      check_eq({tag, "_fei0"},   32'(fei0), 32'd0);
      check_eq({tag, "_stat1"},  32'({busy1, done1, ep1, fev1}), 32'd0);
      check_eq({tag, "_cnt1"},   vn1 | er1, 32'd0);
      check_eq({tag, "_xyz1"},   32'(x1 | y1 | z1 | 16'(addr1)), 32'd0);
   endtask

   function automatic logic [75:0] rand_vec(input bit corrupt);
      logic [15:0] a, b, c, r;
      logic [7:0]  ctl;
      logic [3:0]  f;
      a   = 16'($urandom);
      b   = 16'($urandom);
      c   = 16'($urandom);
      ctl = 8'($urandom);
      r   = fake_res(a, b, c, ctl[5:0]);
      f   = fake_flags(a, b, c, ctl[5:0]);
      if (corrupt && $urandom_range(0, 3) == 0) r = r ^ (16'd1 << $urandom_range(0, 15));
      if (corrupt && $urandom_range(0, 3) == 0) f = f ^ (4'd1 << $urandom_range(0, 3));
      return {a, b, c, ctl, r, f};
   endfunction

   // run n vectors from mem[0..n-1], checking every cycle against the expected schedule:
   // start sampled on edge 1, vector i checked on edge 3i+3, done from edge 3n+1
   task automatic run_check(input int n, input bit poke_busy, input bit start_at_done);
      bit m0 [DEPTH];
      bit m1 [DEPTH];
      int tot0, tot1, f0, f1, nd, r0, r1;
      bit slot;
      logic [75:0] v;
      tot0 = 0; tot1 = 0; f0 = -1; f1 = -1;
      for (int i = 0; i < n; i++) begin
         v = mem[i];
         m0[i] = (v[19:4] != fake_res(v[75:60], v[59:44], v[43:28], v[25:20]));
         m1[i] = m0[i] || (v[3:0] != fake_flags(v[75:60], v[59:44], v[43:28], v[25:20]));
         tot0 += int'(m0[i]);
         tot1 += int'(m1[i]);
         if (m0[i] && f0 < 0) f0 = i;
         if (m1[i] && f1 < 0) f1 = i;
      end
      num_vecs = (AW+1)'(n);
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      for (int k = 1; k <= 3*n + 1; k++) begin
         nd = (k - 1) / 3;
         r0 = 0; r1 = 0;
         for (int i = 0; i < nd; i++) begin
            r0 += int'(m0[i]);
            r1 += int'(m1[i]);
         end
         slot = (k >= 4) && ((k - 1) % 3 == 0);
         check_eq("vectornum0", vn0, 32'(nd));
         check_eq("vectornum1", vn1, 32'(nd));
         check_eq("errors0", er0, 32'(r0));
         check_eq("errors1", er1, 32'(r1));
         check_eq("err_pulse0", 32'(ep0), slot ? 32'(m0[(k-4)/3]) : 32'd0);
         check_eq("err_pulse1", 32'(ep1), slot ? 32'(m1[(k-4)/3]) : 32'd0);
         check_eq("busy0", 32'(busy0), 32'(k <= 3*n));
         check_eq("done0", 32'(done0), 32'(k == 3*n + 1));
         check_eq("done1", 32'(done1), 32'(k == 3*n + 1));
         if (k <= 3*n) begin
            check_eq("vec_addr0", 32'(addr0), 32'(nd));
            check_eq("vec_addr1", 32'(addr1), 32'(nd));
         end
         if (poke_busy && k == 2) begin
            start = 1'b1;
            num_vecs = '0;
         end else if (poke_busy && k == 3) begin
            start = 1'b0;
         end
         if (start_at_done && k == 3*n) start = 1'b1;
         if (k < 3*n + 1) begin
            @(posedge clk); #1;
         end
      end
      start = 1'b0;
      check_eq("final_errors0", er0, 32'(tot0));
      check_eq("final_errors1", er1, 32'(tot1));
      check_eq("first_valid0", 32'(fev0), 32'(f0 >= 0));
      check_eq("first_valid1", 32'(fev1), 32'(f1 >= 0));
      check_eq("first_idx0", 32'(fei0), (f0 >= 0) ? 32'(f0) : 32'd0);
      check_eq("first_idx1", 32'(fei1), (f1 >= 0) ? 32'(f1) : 32'd0);
      if (n > 0) begin
         v = mem[n-1];
         check_eq("hold_x", 32'(x0), 32'(v[75:60]));
         check_eq("hold_y", 32'(y0), 32'(v[59:44]));
         check_eq("hold_z", 32'(z0), 32'(v[43:28]));
         check_eq("hold_ctl", 32'({rm0, mul0, add0, negp0, negz0}), 32'(v[25:20]));
      end
      if (start_at_done) begin
         @(posedge clk); #1;
         check_eq("start_at_entry_done", 32'(done0), 32'd1);
         check_eq("start_at_entry_vn", vn0, 32'(n));
         check_eq("start_at_entry_busy", 32'(busy0), 32'd0);
      end
   endtask

   initial begin
      reset = 1'b0;
      start = 1'b0;
      num_vecs = '0;
      for (int i = 0; i < DEPTH; i++) mem[i] = '0;
      #2 reset = 1'b1;
      #2 check_all_zero("reset");
      @(posedge clk); #1;
      reset = 1'b0;
      @(posedge clk); #1;

      // pass path: 1.0 x 1.0 with mul set
      mem[0] = 76'h3c00_3c00_0000_08_3c00_0;
      run_check(1, 1'b0, 1'b0);
      check_eq("pass_mul", 32'(mul0), 32'd1);
      check_eq("pass_rm", 32'(rm0), 32'd0);
      check_eq("pass_errors", er0, 32'd0);
      check_eq("pass_vn", vn0, 32'd1);

      // result mismatch on the middle vector
      mem[1] = 76'h3c00_3c00_0000_08_3c01_0;
      mem[2] = 76'h3c00_3c00_0000_08_3c00_0;
      run_check(3, 1'b0, 1'b0);
      check_eq("mis_errors", er0, 32'd1);
      check_eq("mis_first_idx", 32'(fei0), 32'd1);
      check_eq("mis_vn", vn0, 32'd3);

      // flag-only mismatch counts only with flag checking enabled
      mem[0] = 76'h3c00_3c00_0000_08_3c00_1;
      run_check(1, 1'b0, 1'b0);
      check_eq("flag_errors_cf0", er0, 32'd0);
      check_eq("flag_errors_cf1", er1, 32'd1);

      // zero-length run, start while busy, start on DONE entry, restart from DONE
      run_check(0, 1'b0, 1'b0);
      for (int i = 0; i < DEPTH; i++) mem[i] = rand_vec(1'b1);
      run_check(3, 1'b1, 1'b0);
      run_check(2, 1'b0, 1'b1);
      run_check(2, 1'b0, 1'b0);

      // reset during APPLY of vector 2, then a clean run from index 0
      num_vecs = (AW+1)'(3);
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (7) begin
         @(posedge clk); #1;
      end
      check_eq("pre_reset_busy", 32'(busy0), 32'd1);
      reset = 1'b1;
      #1 check_all_zero("midrun_reset");
      @(posedge clk); #1;
      reset = 1'b0;
      run_check(3, 1'b0, 1'b0);

      // full depth, every vector passing
      for (int i = 0; i < DEPTH; i++) mem[i] = rand_vec(1'b0);
      run_check(DEPTH, 1'b0, 1'b0);
      check_eq("full_vn", vn0, 32'd16);
      check_eq("full_errors", er1, 32'd0);

      // random runs with random corruption
      for (int it = 0; it < 10; it++) begin
         for (int i = 0; i < DEPTH; i++) mem[i] = rand_vec(1'b1);
         run_check(int'($urandom_range(1, DEPTH)), 1'b0, 1'b0);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
